// File: rtl/updown_counter_param.sv
// -----------------------------------------------------------------------------
// updown_counter_param
//
// Parametrised up/down event/timebase counter. It supports:
//   - a synchronous parallel load, clamped to MAX_VAL
//   - wrap or saturate behaviour at the count limits
//   - a one-cycle terminal-count pulse
//   - a sticky overflow flag
//
// Optional feature macro: COUNTER_PRESCALE_EN
//   When this macro is defined, an internal prescaler divides the enabled
//   edges by PRESCALE_DIV. When it is undefined, every enabled edge is a
//   count step and PRESCALE_DIV is ignored.
//
// Parameters:
//   WIDTH        counter width in bits (>= 2)
//   MAX_VAL      upper count limit (1 .. 2**WIDTH-1)
//   SATURATE     0 = wrap at the limits, 1 = hold at the limits
//   PRESCALE_DIV step divider (>= 2), used only with COUNTER_PRESCALE_EN
//
// Ports:
//   clk        system clock; all logic runs on the rising edge
//   reset      synchronous, active-high reset
//   enable     count enable
//   count_dir  1 = count up, 0 = count down
//   load       synchronous load strobe; it has priority over enable
//   load_val   value to load; values above MAX_VAL are clamped
//   clear_ovf  clears the sticky ovf flag; a boundary event on the same edge wins
//   count      registered counter value
//   tc         registered terminal-count pulse, one cycle after a boundary step
//   ovf        registered sticky boundary-crossing flag
// -----------------------------------------------------------------------------
module updown_counter_param #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned MAX_VAL      = 2**WIDTH - 1,
  parameter int unsigned SATURATE     = 0,
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             count_dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  // Reject illegal configurations at elaboration time.
  if (WIDTH < 2) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be >= 2");
  end
  if ((MAX_VAL < 1) || (MAX_VAL > (2**WIDTH - 1))) begin : g_bad_max
    $error("updown_counter_param: MAX_VAL must lie in 1 .. 2**WIDTH-1");
  end
  if (PRESCALE_DIV < 2) begin : g_bad_div
    $error("updown_counter_param: PRESCALE_DIV must be >= 2");
  end

  logic step;

`ifdef COUNTER_PRESCALE_EN
  localparam int unsigned PW = $clog2(PRESCALE_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);

  logic [PW-1:0] prescale;

  // Prescaler: it advances on enabled non-load edges and returns to 0 on the stepping edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= {PW{1'b0}};
    end else if (load) begin
      prescale <= {PW{1'b0}};
    end else if (enable) begin
      if (prescale == PRE_LAST) begin
        prescale <= {PW{1'b0}};
      end else begin
        prescale <= prescale + PRE_ONE;
      end
    end else begin
      prescale <= prescale;
    end
  end

  assign step = enable & ~load & (prescale == PRE_LAST);
`else
  assign step = enable & ~load;
`endif

  logic [WIDTH-1:0] count_nxt;
  logic             ovf_nxt;
  logic             boundary;

  // Next-state logic: load clamps, a step either moves by one or hits a limit.
  always_comb begin
    count_nxt = count;
    boundary  = 1'b0;
    if (load) begin
      if (load_val > LIMIT) begin
        count_nxt = LIMIT;
      end else begin
        count_nxt = load_val;
      end
    end else if (step) begin
      if (count_dir) begin
        if (count == LIMIT) begin
          boundary  = 1'b1;
          count_nxt = (SATURATE != 0) ? LIMIT : ZERO;
        end else begin
          count_nxt = count + ONE;
        end
      end else begin
        if (count == ZERO) begin
          boundary  = 1'b1;
          count_nxt = (SATURATE != 0) ? ZERO : LIMIT;
        end else begin
          count_nxt = count - ONE;
        end
      end
    end else begin
      count_nxt = count;
    end

    // A boundary event on the same edge as clear_ovf leaves the flag set.
    if (boundary) begin
      ovf_nxt = 1'b1;
    end else if (clear_ovf) begin
      ovf_nxt = 1'b0;
    end else begin
      ovf_nxt = ovf;
    end
  end

  // Output registers. Reset has priority; load and step priority is resolved above.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= ZERO;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= boundary;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// -----------------------------------------------------------------------------
// tb_updown_counter_param
//
// This bench runs three counter instances in parallel from shared stimulus:
//   a: WIDTH=4, MAX_VAL=9, wrap
//   b: WIDTH=4, MAX_VAL=9, saturate
//   c: WIDTH=4, MAX_VAL=1, wrap
// The driver pushes reference-model predictions into a queue. A monitor pops
// them after each rising edge and compares them with the instance outputs.
// Directed scenarios also check fixed expected values.
// -----------------------------------------------------------------------------
module tb_updown_counter_param;

  localparam int W    = 4;
  localparam int PDIV = 4;

  logic clk = 1'b0;
  logic reset, enable, count_dir, load, clear_ovf;
  logic [W-1:0] load_val;
  logic [W-1:0] count_a, count_b, count_c;
  logic tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c;

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(W), .MAX_VAL(9), .SATURATE(0), .PRESCALE_DIV(PDIV)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .count_dir(count_dir), .load(load),
    .load_val(load_val), .clear_ovf(clear_ovf), .count(count_a), .tc(tc_a), .ovf(ovf_a));
  updown_counter_param #(.WIDTH(W), .MAX_VAL(9), .SATURATE(1), .PRESCALE_DIV(PDIV)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .count_dir(count_dir), .load(load),
    .load_val(load_val), .clear_ovf(clear_ovf), .count(count_b), .tc(tc_b), .ovf(ovf_b));
  updown_counter_param #(.WIDTH(W), .MAX_VAL(1), .SATURATE(0), .PRESCALE_DIV(PDIV)) dut_c (
    .clk(clk), .reset(reset), .enable(enable), .count_dir(count_dir), .load(load),
    .load_val(load_val), .clear_ovf(clear_ovf), .count(count_c), .tc(tc_c), .ovf(ovf_c));

  typedef struct {
    int cnt;
    bit tc;
    bit ovf;
    int pre;
  } st_t;

  st_t m [3];
  int  maxv [3];
  bit  satv [3];
  st_t expq [$];

  int checks   = 0;
  int failures = 0;

  // Reference model: this is plain integer arithmetic on the counting rules.
  function automatic st_t model(st_t s, int mx, bit sat, bit r, bit e, bit d, bit l, int lv, bit c);
    st_t n;
    bit  stp;
    int  t;
    n    = s;
    n.tc = 1'b0;
    if (r) begin
      n.cnt = 0; n.ovf = 1'b0; n.pre = 0;
      return n;
    end
    if (l) begin
      n.cnt = (lv > mx) ? mx : lv;
      n.pre = 0;
      if (c) n.ovf = 1'b0;
      return n;
    end
    stp = e;
`ifdef COUNTER_PRESCALE_EN
    if (e) begin
      if (s.pre == PDIV - 1) n.pre = 0;
      else begin n.pre = s.pre + 1; stp = 1'b0; end
    end
`endif
    if (stp) begin
      t = d ? s.cnt + 1 : s.cnt - 1;
      if (t > mx || t < 0) begin
        n.tc  = 1'b1;
        n.ovf = 1'b1;
        n.cnt = sat ? s.cnt : ((t > mx) ? 0 : mx);
        return n;
      end
      n.cnt = t;
    end
    if (c) n.ovf = 1'b0;
    return n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, predict the result, then wait until just after the rising edge.
  task automatic drive(bit r, bit e, bit d, bit l, int lv, bit c);
    @(negedge clk);
    reset = r; enable = e; count_dir = d; load = l; clear_ovf = c;
    load_val = W'(lv);
    for (int i = 0; i < 3; i++) begin
      m[i] = model(m[i], maxv[i], satv[i], r, e, d, l, lv % 16, c);
      expq.push_back(m[i]);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop one prediction per instance after each rising edge and compare it.
  initial begin
    st_t ex;
    forever begin
      @(posedge clk);
      #2;
      if (expq.size() >= 3) begin
        ex = expq.pop_front();
        chk("a_cnt", 32'(count_a), 32'(ex.cnt)); chk("a_tc", 32'(tc_a), 32'(ex.tc)); chk("a_ovf", 32'(ovf_a), 32'(ex.ovf));
        ex = expq.pop_front();
        chk("b_cnt", 32'(count_b), 32'(ex.cnt)); chk("b_tc", 32'(tc_b), 32'(ex.tc)); chk("b_ovf", 32'(ovf_b), 32'(ex.ovf));
        ex = expq.pop_front();
        chk("c_cnt", 32'(count_c), 32'(ex.cnt)); chk("c_tc", 32'(tc_c), 32'(ex.tc)); chk("c_ovf", 32'(ovf_c), 32'(ex.ovf));
      end
    end
  end

  initial begin
    maxv[0] = 9; maxv[1] = 9; maxv[2] = 1;
    satv[0] = 1'b0; satv[1] = 1'b1; satv[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m[i].cnt = 0; m[i].tc = 1'b0; m[i].ovf = 1'b0; m[i].pre = 0;
    end
    reset = 1'b1; enable = 1'b0; count_dir = 1'b1; load = 1'b0; clear_ovf = 1'b0; load_val = '0;

    drive(1, 0, 1, 0, 0, 0);
    chk("reset_cnt", 32'(count_a), 32'd0);
    chk("reset_tc", 32'(tc_a), 32'd0);
    chk("reset_ovf", 32'(ovf_a), 32'd0);

`ifndef COUNTER_PRESCALE_EN
    // Count up 12 edges with wrap at 9.
    for (int k = 1; k <= 12; k++) begin
      drive(0, 1, 1, 0, 0, 0);
      chk("up_cnt", 32'(count_a), 32'(k % 10));
      chk("up_tc", 32'(tc_a), (k == 10) ? 32'd1 : 32'd0);
      chk("up_ovf", 32'(ovf_a), (k >= 10) ? 32'd1 : 32'd0);
    end

    // Count down from reset, then clear ovf.
    drive(1, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    chk("dn_cnt9", 32'(count_a), 32'd9); chk("dn_tc", 32'(tc_a), 32'd1); chk("dn_ovf", 32'(ovf_a), 32'd1);
    drive(0, 1, 0, 0, 0, 0);
    chk("dn_cnt8", 32'(count_a), 32'd8); chk("dn_tc0", 32'(tc_a), 32'd0);
    drive(0, 1, 0, 0, 0, 0);
    chk("dn_cnt7", 32'(count_a), 32'd7);
    drive(0, 0, 0, 0, 0, 1);
    chk("clr_ovf", 32'(ovf_a), 32'd0); chk("clr_hold", 32'(count_a), 32'd7);

    // Saturating instance: load 8, then count up 3 edges.
    drive(1, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 8, 0);
    chk("sat_load", 32'(count_b), 32'd8);
    drive(0, 1, 1, 0, 0, 0);
    chk("sat_up1", 32'(count_b), 32'd9); chk("sat_tc1", 32'(tc_b), 32'd0);
    drive(0, 1, 1, 0, 0, 0);
    chk("sat_up2", 32'(count_b), 32'd9); chk("sat_tc2", 32'(tc_b), 32'd1);
    drive(0, 1, 1, 0, 0, 0);
    chk("sat_up3", 32'(count_b), 32'd9); chk("sat_tc3", 32'(tc_b), 32'd1); chk("sat_ovf", 32'(ovf_b), 32'd1);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    chk("sat_dn0", 32'(count_b), 32'd0); chk("sat_dn_tc", 32'(tc_b), 32'd1);

    // Load clamp, load priority over enable, and set winning over clear.
    drive(0, 0, 1, 1, 15, 0);
    chk("clamp_a", 32'(count_a), 32'd9); chk("clamp_c", 32'(count_c), 32'd1);
    drive(0, 1, 1, 1, 3, 0);
    chk("load_win", 32'(count_a), 32'd3); chk("load_tc", 32'(tc_a), 32'd0);
    drive(0, 0, 1, 1, 9, 1);
    chk("load_clr", 32'(ovf_a), 32'd0); chk("load9", 32'(count_a), 32'd9);
    drive(0, 1, 1, 0, 0, 1);
    chk("set_wins", 32'(ovf_a), 32'd1); chk("set_cnt", 32'(count_a), 32'd0); chk("set_tc", 32'(tc_a), 32'd1);

    // Reset in the middle of counting.
    drive(1, 0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) drive(0, 1, 1, 0, 0, 0);
    chk("mid_cnt5", 32'(count_a), 32'd5);
    drive(1, 1, 1, 0, 0, 0);
    chk("mid_rst", 32'(count_a), 32'd0); chk("mid_tc", 32'(tc_a), 32'd0); chk("mid_ovf", 32'(ovf_a), 32'd0);
    drive(0, 1, 1, 0, 0, 0);
    chk("mid_r1", 32'(count_a), 32'd1); chk("c_toggle1", 32'(count_c), 32'd1); chk("c_tc0", 32'(tc_c), 32'd0);
    drive(0, 1, 1, 0, 0, 0);
    chk("mid_r2", 32'(count_a), 32'd2); chk("c_toggle0", 32'(count_c), 32'd0); chk("c_tc1", 32'(tc_c), 32'd1);
`else
    // Prescaled stepping: count advances only on every PDIV-th enabled edge.
    for (int k = 1; k <= 8; k++) begin
      drive(0, 1, 1, 0, 0, 0);
      chk("pre_cnt", 32'(count_a), 32'(k / PDIV));
    end
    for (int k = 0; k < 3; k++) drive(0, 1, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    chk("pre_hold", 32'(count_a), 32'd2);
    drive(0, 1, 1, 0, 0, 0);
    chk("pre_delayed", 32'(count_a), 32'd3);
    drive(0, 0, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) drive(0, 1, 1, 0, 0, 0);
    chk("pre_load_wait", 32'(count_a), 32'd0);
    drive(0, 1, 1, 0, 0, 0);
    chk("pre_load_step", 32'(count_a), 32'd1);
`endif

    // Randomised traffic, checked only through the scoreboard.
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(99) < 2), ($urandom_range(99) < 70), 1'($urandom_range(1)),
            ($urandom_range(99) < 10), int'($urandom_range(15)), ($urandom_range(99) < 10));
    end

    repeat (2) @(posedge clk);
    #5;
    chk("drain", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
